counter_four_bits_down: RTL

- Loadable down counter; decrementing counterpart of the team's 4-bit up counter.
- Counts from a loaded value toward zero.
- Two modes: wrap-around (free-running) or one-shot (stop at zero, flag done).
- Provides a borrow output so stages chain into wider down counters and timeout timers.

---
 rtl/counter_four_bits_down.sv | 109 ++++++++++
 1 files changed

// File: rtl/counter_four_bits_down.sv
// Loadable down counter with wrap-around or one-shot (stop at zero) modes and a borrow-out for cascading.
// Optional build macro COUNTER_DOWN_BCD_EN (WIDTH must be 4): decade stage, wrap target 9, loads clamped to 9.
module counter_four_bits_down #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             one_shot,
  output logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             bout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] w_load_eff;
  logic             w_zero;

`ifdef COUNTER_DOWN_BCD_EN
  localparam logic [WIDTH-1:0] WRAP_V = WIDTH'(9);
  assign w_load_eff = (load_value > WRAP_V) ? WRAP_V : load_value;
`else
  localparam logic [WIDTH-1:0] WRAP_V = {WIDTH{1'b1}};
  assign w_load_eff = load_value;
`endif

  assign w_zero = (r_data == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_nxt = RUN;
          w_data_nxt  = w_load_eff;
        end
      end
      RUN: begin
        if (load) begin
          w_data_nxt = w_load_eff;
        end else if (en) begin
          if (w_zero) begin
            // A zero reached here in one-shot mode was loaded directly.
            if (one_shot) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_data_nxt = WRAP_V;
            end
          end else begin
            w_data_nxt = r_data - ONE_V;
            if (one_shot && (r_data == ONE_V)) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (load) begin
          w_state_nxt = RUN;
          w_data_nxt  = w_load_eff;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_data_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Borrow-out is suppressed by load so a reloading stage never ripples a borrow upward.
  assign data    = r_data;
  assign zero    = w_zero;
  assign busy    = (r_state == RUN);
  assign done    = r_done;
  assign bout    = en & w_zero & (r_state == RUN) & ~load;
  assign o_state = r_state;

endmodule
